// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU.
// Optional single-cycle multiplier enabled by defining MULDIV_FAST_MUL_EN.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  // Handshake: EX holds start high from the accept cycle until result_valid;
  // stall freezes the pipe meanwhile, result_valid pulses for exactly one cycle
  // (DONE, stall low) and start seen in DONE belongs to the finishing op.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state, state_next;
  logic [4:0]  count;
  logic [2:0]  op;
  logic [63:0] acc;
  logic [32:0] rem;
  logic [31:0] b_abs;
  logic        neg_res, neg_rem;
  logic [31:0] pend, result_q;

  logic        is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, special, fast;
  logic [31:0] special_res, fast_res;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = is_div ? ~funct3[0] : (funct3 != 3'b011);
    b_sgn    = is_div ? ~funct3[0] : ~funct3[1];
    a_neg    = a_sgn & rs1[31];
    b_neg    = b_sgn & rs2[31];
    a_mag    = a_neg ? (32'd0 - rs1) : rs1;
    b_mag    = b_neg ? (32'd0 - rs2) : rs2;
    div_zero = is_div & (rs2 == 32'd0);
    div_ovf  = is_div & ~funct3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = funct3[1] ? rs1 : 32'hFFFF_FFFF;
    else          special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extended 64-bit operands: the low 64 product bits equal the 33x33 signed product.
  logic [63:0] a_ext, b_ext, fast_prod;
  always_comb begin
    a_ext     = {{32{a_sgn & rs1[31]}}, rs1};
    b_ext     = {{32{b_sgn & rs2[31]}}, rs2};
    fast_prod = a_ext * b_ext;
    fast      = ~is_div;
    fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
  end
`else
  always_comb begin
    fast     = 1'b0;
    fast_res = 32'd0;
  end
`endif

  // One radix-2 step: shift-add multiply or restoring divide.
  logic [32:0] sum33;
  logic [63:0] mul_next;
  logic [33:0] shifted;
  logic        q_bit;
  logic [32:0] diff, rem_next;
  logic [31:0] q_next;
  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s, final_res;

  always_comb begin
    sum33     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_abs} : 33'd0);
    mul_next  = {sum33, acc[31:1]};
    shifted   = {rem, acc[31]};
    q_bit     = (shifted >= {2'b00, b_abs});
    diff      = shifted[32:0] - {1'b0, b_abs};
    rem_next  = q_bit ? diff : shifted[32:0];
    q_next    = {acc[30:0], q_bit};
    prod_s    = neg_res ? (64'd0 - mul_next) : mul_next;
    quot_s    = neg_res ? (32'd0 - q_next) : q_next;
    rem_s     = neg_rem ? (32'd0 - rem_next[31:0]) : rem_next[31:0];
    if (op[2])             final_res = op[1] ? rem_s : quot_s;
    else if (op == 3'b000) final_res = prod_s[31:0];
    else                   final_res = prod_s[63:32];
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start & ~kill) state_next = (special | fast) ? S_DONE : S_CALC;
      S_CALC: if (kill) state_next = S_IDLE;
              else if (count == 5'd0) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      count    <= 5'd0;
      op       <= 3'd0;
      acc      <= 64'd0;
      rem      <= 33'd0;
      b_abs    <= 32'd0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      pend     <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      case (state)
        S_IDLE: if (start & ~kill) begin
          op      <= funct3;
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          acc     <= {32'd0, a_mag};
          rem     <= 33'd0;
          b_abs   <= b_mag;
          count   <= 5'd31;
          if (special)   pend <= special_res;
          else if (fast) pend <= fast_res;
        end
        S_CALC: if (!kill) begin
          acc   <= op[2] ? {acc[63:32], q_next} : mul_next;
          rem   <= rem_next;
          count <= (count == 5'd0) ? 5'd0 : count - 5'd1;
          if (count == 5'd0) pend <= final_res;
        end
        default: if (!kill) result_q <= pend;
      endcase
    end
  end

  // A kill in DONE suppresses the pulse and leaves the previous result visible.
  always_comb begin
    stall        = ((state == S_IDLE) & start & ~kill) | (state == S_CALC);
    result_valid = (state == S_DONE) & ~kill;
    result       = result_valid ? pend : result_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic, latency, special cases,
// kill, mid-operation reset and back-to-back issue.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .stall(stall), .busy(busy),
    .result_valid(result_valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents an op in the current (IDLE) cycle T and follows it to result_valid.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit hold);
    int  n;
    bit  stall_gap;
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1; kill = 1'b0;
    #1;
    chk({tag, "_stall_T"}, 32'(stall), 32'd1);
    chk({tag, "_rv_T"}, 32'(result_valid), 32'd0);
    n = 0;
    stall_gap = 1'b0;
    do begin
      tick();
      n++;
      if (!result_valid && !stall) stall_gap = 1'b1;
    end while (!result_valid && n < 60);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_stall_gap"}, 32'(stall_gap), 32'd0);
    if (!hold) start = 1'b0;
  endtask

  initial begin
    bit saw_rv;

    // Reset state
    #12;
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Multiplies
    run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b0);
    tick();
    chk("mul_held", result, 32'hFFFF_FFEB);
    chk("mul_rv_drop", 32'(result_valid), 32'd0);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
    tick();
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
    tick();
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 1'b0);
    tick();

    // Divides
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    tick();
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    tick();
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    tick();
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    tick();

    // Special cases resolve in one cycle
    run_op("divu_by0", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    tick();
    run_op("rem_by0", 3'b110, 32'd100, 32'd0, 32'd100, 1, 1'b0);
    tick();
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    tick();
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    tick();

    // Kill during CALC at T+10
    funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    saw_rv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result_valid) saw_rv = 1'b1;
    end
    chk("kill_busy_T10", 32'(busy), 32'd1);
    chk("kill_stall_T10", 32'(stall), 32'd1);
    kill = 1'b1;
    tick();
    chk("kill_busy_T11", 32'(busy), 32'd0);
    chk("kill_stall_T11", 32'(stall), 32'd0);
    chk("kill_result_kept", result, 32'd0);
    tick();
    if (result_valid) saw_rv = 1'b1;
    chk("kill_wins_idle", 32'(busy), 32'd0);
    chk("kill_no_rv", 32'(saw_rv), 32'd0);
    kill = 1'b0;
    run_op("mul_after_kill", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b0);
    tick();

    // Reset in the middle of an op
    funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rv", 32'(result_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_rv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (result_valid || busy) saw_rv = 1'b1;
    end
    chk("midrst_quiet", 32'(saw_rv), 32'd0);

    // Back-to-back: start stays high through DONE and the next op issues right after
    run_op("b2b_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    chk("b2b_done_busy", 32'(busy), 32'd1);
    tick();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    run_op("b2b_mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle EX-stage ALU does not execute. It sits beside the ALU in EX and accepts an M-extension R-type instruction (funct7 = 0000001) decoded by ALU control. It stalls the pipeline while it iterates, then returns one 32-bit result for the writeback path. Divide-by-zero and signed-overflow cases are resolved in one cycle without iterating.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: EX holds an M-extension op; held high by EX for the whole stall.
- `kill` input 1: pipeline flush of the EX instruction; aborts any operation in progress.
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1` input XLEN: operand A (dividend/multiplicand).
- `rs2` input XLEN: operand B (divisor/multiplier).
- `stall` output 1: freeze IF/ID/EX; combinational.
- `busy` output 1: FSM is not in IDLE; registered.
- `result_valid` output 1: one-cycle pulse; `result` is valid.
- `result` output XLEN: operation result; registered and held until the next result.

## Operation
- FSM states: IDLE, CALC, DONE. Reset enters IDLE.
- IDLE:
  - Move to CALC when `start & ~kill`.
  - Go directly to DONE instead if the op is a special case.
  - Capture funct3, absolute-value operands and sign flags; load `count` = 31.
- CALC:
  - One radix-2 step per cycle.
  - Multiply: unsigned shift-add, 64-bit accumulator.
  - Divide: restoring divide on a 33-bit partial remainder.
  - `count` decrements each step; after the step where `count` = 0, go to DONE.
  - 32 steps total.
- DONE:
  - Assert `result_valid`, register the sign-corrected `result`, return to IDLE.
  - `start` is ignored in DONE, because it still belongs to the completing instruction.
- `kill` in CALC or DONE: return to IDLE at the next edge. No `result_valid`; `result` keeps its old value.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Sign correction:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
- Result selection:
  - MUL returns the low 32 bits of the product.
  - MULH, MULHSU, MULHU return the high 32 bits.
- Special cases (IDLE→DONE, no iteration):
  - Divisor 0: quotient 0xFFFFFFFF, remainder = rs1.
  - DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `stall` = `(IDLE & start & ~kill) | CALC`. It is low in DONE so EX advances in the same cycle `result_valid` is high.

## Timing
- Reset values: state IDLE, `busy` 0, `result_valid` 0, `result` 0, `count` 0.
- `stall` is combinational; with `start` low it is 0 out of reset.
- Latency, with `start` sampled in IDLE at edge T:
  - Iterative op: `result_valid` high in cycle T+33.
  - Special case: `result_valid` high in cycle T+1.
- Back-to-back ops: the next `start` is accepted in the IDLE cycle immediately after DONE. Throughput is 34 cycles per iterative op.
- `rst_n` asserted mid-operation: immediate return to reset values, with no pulse on deassertion.
- `kill` and `start` high together in IDLE: `kill` wins; stay in IDLE and keep `stall` low.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL, MULH, MULHSU and MULHU use a single-cycle 33×33 signed multiplier.
  - IDLE goes directly to DONE, so `result_valid` is high at T+1.
  - Divides stay iterative.
- `MULDIV_FAST_MUL_EN` undefined: all multiplies iterate, with 33-cycle latency as above.

## Test plan
- MUL rs1 = 7, rs2 = 0xFFFFFFFD → `result` 0xFFFFFFEB with `result_valid` at T+33, or T+1 with `MULDIV_FAST_MUL_EN`. `stall` is high for cycles T through T+32.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 100 / 0 → 0xFFFFFFFF, REM 100 / 0 → 100, and DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. Each has `result_valid` at T+1.
- Kill and reset recovery:
  - `kill` at T+10 of a DIV: no `result_valid` and `stall` low from T+11.
  - A new MUL with `start` at T+11 completes correctly.
  - `rst_n` low at T+5 yields all reset values.
- Back-to-back DIVU then MUL: second `start` accepted in the cycle after the first `result_valid`. Both results are correct, and `stall` is low for exactly the DONE cycle between them.
